// File: rtl/gpio_in_debounce_irq_if.sv
// Avalon-MM slave register bus for gpio_in_debounce_irq: the host drives
// address/chipselect/write_n/writedata, the PIO returns readdata one clock later.
interface gpio_in_debounce_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    // Write takes effect when chipselect is high and write_n is low on a rising
    // clk edge; readdata always reflects the register selected on the previous edge.
    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/gpio_in_debounce_irq.sv
// Input PIO: per-bit two-flop synchroniser, optional debounce, edge capture
// register (per-bit W1C or clear-all) and a masked level interrupt.
module gpio_in_debounce_irq #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0,
    parameter int BIT_CLEAR       = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    gpio_in_debounce_irq_if.slave bus,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_irq_mask;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_ec_next;
    logic             w_wr;
    logic             w_wr_mask;
    logic             w_wr_ec;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_stable <= '0;
                end else begin
                    r_stable <= r_sync2;
                end
            end
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt [WIDTH];

            // The counter only runs while the synchronised input disagrees with
            // the accepted value, so any bounce back restarts the qualification.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_stable <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (r_sync2[i] == r_stable[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_stable[i] <= r_sync2[i];
                            r_cnt[i]    <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_d <= '0;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    assign w_rise = r_stable & ~r_stable_d;
    assign w_fall = ~r_stable & r_stable_d;
    assign w_edge = (EDGE_TYPE == 0) ? w_rise :
                    (EDGE_TYPE == 1) ? w_fall : (w_rise | w_fall);

    assign w_wr      = bus.chipselect & ~bus.write_n;
    assign w_wr_mask = w_wr & (bus.address == 2'd2);
    assign w_wr_ec   = w_wr & (bus.address == 2'd3);
    assign w_wdata   = bus.writedata[WIDTH-1:0];
    assign w_unused  = &{1'b0, bus.writedata};

    generate
        if (BIT_CLEAR != 0) begin : g_w1c
            // A new edge in the clearing cycle survives, so no event is lost.
            assign w_ec_next = w_edge | (r_edge_capture & ~(w_wdata & {WIDTH{w_wr_ec}}));
        end else begin : g_clear_all
            assign w_ec_next = w_wr_ec ? '0 : (r_edge_capture | w_edge);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_capture <= '0;
            r_irq_mask     <= '0;
        end else begin
            r_edge_capture <= w_ec_next;
            if (w_wr_mask) begin
                r_irq_mask <= w_wdata;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            2'd0:    w_rd_mux = 32'(r_stable);
            2'd2:    w_rd_mux = 32'(r_irq_mask);
            2'd3:    w_rd_mux = 32'(r_edge_capture);
            default: w_rd_mux = '0;
        endcase
    end

    // Read path ignores chipselect; an addr-3 read shows the pre-clear value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_gpio_in_debounce_irq.sv
// Bench for gpio_in_debounce_irq: three builds driven by one bus stream and
// compared each clock against a behavioural model, plus directed vectors.
module tb_gpio_in_debounce_irq;

    localparam int NDUT = 3;
    localparam int M_W  [NDUT] = '{10, 10, 32};
    localparam int M_DB [NDUT] = '{0, 4, 0};
    localparam int M_ET [NDUT] = '{0, 2, 2};
    localparam int M_BC [NDUT] = '{1, 1, 0};
    localparam int HIST = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] in_drv = '0;
    logic        irq0, irq1, irq2;

    gpio_in_debounce_irq_if bus0();
    gpio_in_debounce_irq_if bus1();
    gpio_in_debounce_irq_if bus2();

    gpio_in_debounce_irq #(.WIDTH(10), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .BIT_CLEAR(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_drv[9:0]), .irq(irq0));
    gpio_in_debounce_irq #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .BIT_CLEAR(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_drv[9:0]), .irq(irq1));
    gpio_in_debounce_irq #(.WIDTH(32), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .BIT_CLEAR(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_drv), .irq(irq2));

    // ---------------- reference model state ----------------
    logic [31:0] m_s1   [NDUT];
    logic [31:0] m_s2   [NDUT];
    logic [31:0] m_st   [NDUT];
    logic [31:0] m_std  [NDUT];
    logic [31:0] m_ec   [NDUT];
    logic [31:0] m_mask [NDUT];
    logic [31:0] m_rd   [NDUT];
    logic        m_irq  [NDUT];
    logic [31:0] m_win  [NDUT][HIST];
    int          m_wn   [NDUT];

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] s_rd  [NDUT];
    logic        s_irq [NDUT];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] inp;
        logic [1:0]  a;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;
    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int n);
        m_s1[n] = '0; m_s2[n] = '0; m_st[n] = '0; m_std[n] = '0;
        m_ec[n] = '0; m_mask[n] = '0; m_rd[n] = '0; m_irq[n] = 1'b0;
        m_wn[n] = 0;
        for (int j = 0; j < HIST; j++) m_win[n][j] = '0;
    endtask

    // One rising edge of build n, computed from the register-level rules:
    // accepted value changes once the synchronised input has disagreed with it
    // for the last DEBOUNCE_CYCLES samples.
    task automatic model_step(input int n, input logic [31:0] inp, input logic [1:0] a,
                              input logic cs, input logic wn, input logic [31:0] wd,
                              input logic rst_n);
        logic [31:0] wm, rise, fall, ed, rd_n, ec_n, mask_n, st_n, diff;
        logic wr;
        if (!rst_n) begin
            model_reset(n);
            return;
        end
        wm   = (M_W[n] == 32) ? 32'hFFFF_FFFF : ((32'd1 << M_W[n]) - 32'd1);
        rise = m_st[n] & ~m_std[n];
        fall = ~m_st[n] & m_std[n];
        case (M_ET[n])
            0:       ed = rise;
            1:       ed = fall;
            default: ed = rise | fall;
        endcase
        wr = cs && !wn;
        case (a)
            2'd0:    rd_n = m_st[n];
            2'd2:    rd_n = m_mask[n];
            2'd3:    rd_n = m_ec[n];
            default: rd_n = '0;
        endcase
        if (wr && a == 2'd3) ec_n = (M_BC[n] != 0) ? (ed | (m_ec[n] & ~wd)) : 32'h0;
        else                 ec_n = m_ec[n] | ed;
        ec_n   = ec_n & wm;
        mask_n = (wr && a == 2'd2) ? (wd & wm) : m_mask[n];
        if (M_DB[n] == 0) begin
            st_n = m_s2[n];
        end else begin
            for (int j = HIST - 1; j > 0; j--) m_win[n][j] = m_win[n][j-1];
            m_win[n][0] = m_s2[n];
            if (m_wn[n] < HIST) m_wn[n]++;
            diff = 32'hFFFF_FFFF;
            if (m_wn[n] < M_DB[n]) diff = '0;
            else for (int j = 0; j < M_DB[n]; j++) diff &= m_win[n][j] ^ m_st[n];
            st_n = m_st[n] ^ diff;
        end
        m_std[n]  = m_st[n];
        m_st[n]   = st_n;
        m_s2[n]   = m_s1[n];
        m_s1[n]   = inp & wm;
        m_ec[n]   = ec_n;
        m_mask[n] = mask_n;
        m_rd[n]   = rd_n;
        m_irq[n]  = |(ec_n & mask_n);
    endtask

    task automatic sample_outputs();
        s_rd[0] = bus0.readdata; s_irq[0] = irq0;
        s_rd[1] = bus1.readdata; s_irq[1] = irq1;
        s_rd[2] = bus2.readdata; s_irq[2] = irq2;
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic [31:0] inp, input logic [1:0] a, input logic cs,
                         input logic wn, input logic [31:0] wd);
        logic [31:0] e;
        in_drv = inp;
        bus0.address = a; bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = wd;
        bus1.address = a; bus1.chipselect = cs; bus1.write_n = wn; bus1.writedata = wd;
        bus2.address = a; bus2.chipselect = cs; bus2.write_n = wn; bus2.writedata = wd;
        @(posedge clk);
        for (int n = 0; n < NDUT; n++) begin
            model_step(n, inp, a, cs, wn, wd, reset_n);
            exp_q.push_back(m_rd[n]);
        end
        #1;
        sample_outputs();
        for (int n = 0; n < NDUT; n++) begin
            e = exp_q.pop_front();
            check($sformatf("model_rd%0d", n), s_rd[n], e);
            check($sformatf("model_irq%0d", n), {31'b0, s_irq[n]}, {31'b0, m_irq[n]});
        end
    endtask

    task automatic idle(input int cycles, input logic [1:0] a);
        for (int i = 0; i < cycles; i++) cycle(in_drv, a, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic do_reset(input logic [31:0] inp);
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) cycle(inp, 2'd0, 1'b0, 1'b1, 32'h0);
        reset_n = 1'b1;
    endtask

    task automatic async_reset_check();
        #2;
        reset_n = 1'b0;
        #1;
        for (int n = 0; n < NDUT; n++) model_reset(n);
        sample_outputs();
        for (int n = 0; n < NDUT; n++) begin
            check($sformatf("async_rst_rd%0d", n), s_rd[n], m_rd[n]);
            check($sformatf("async_rst_irq%0d", n), {31'b0, s_irq[n]}, {31'b0, m_irq[n]});
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        logic [31:0] v;
        logic [31:0] r;

        bus0.address = '0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
        bus1.address = '0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
        bus2.address = '0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;
        for (int n = 0; n < NDUT; n++) model_reset(n);

        // Reset with inputs held high: data visible by clock 4, rising captures all.
        do_reset(32'h3FF);
        idle(4, 2'd0);
        check("rst_data", s_rd[0], 32'h3FF);
        idle(1, 2'd3);
        check("rst_ec", s_rd[0], 32'h3FF);
        check("rst_irq", {31'b0, s_irq[0]}, 32'h0);

        // Table: rising, no debounce, mask/clear/reserved/RO behaviour on build 0.
        tbl[0]  = '{32'h000, 2'd2, 1'b1, 1'b0, 32'h001,      32'h000, 1'b0};
        tbl[1]  = '{32'h001, 2'd2, 1'b0, 1'b1, 32'h000,      32'h001, 1'b0};
        tbl[2]  = '{32'h000, 2'd3, 1'b0, 1'b1, 32'h000,      32'h000, 1'b0};
        tbl[3]  = '{32'h000, 2'd3, 1'b0, 1'b1, 32'h000,      32'h000, 1'b0};
        tbl[4]  = '{32'h000, 2'd3, 1'b0, 1'b1, 32'h000,      32'h000, 1'b1};
        tbl[5]  = '{32'h000, 2'd3, 1'b0, 1'b1, 32'h000,      32'h001, 1'b1};
        tbl[6]  = '{32'h000, 2'd0, 1'b0, 1'b1, 32'h000,      32'h000, 1'b1};
        tbl[7]  = '{32'h000, 2'd3, 1'b1, 1'b0, 32'h001,      32'h001, 1'b0};
        tbl[8]  = '{32'h000, 2'd3, 1'b0, 1'b1, 32'h000,      32'h000, 1'b0};
        tbl[9]  = '{32'h000, 2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h000, 1'b0};
        tbl[10] = '{32'h000, 2'd0, 1'b1, 1'b0, 32'h3FF,      32'h000, 1'b0};
        tbl[11] = '{32'h3FF, 2'd2, 1'b0, 1'b1, 32'h000,      32'h001, 1'b0};
        tbl[12] = '{32'h3FF, 2'd0, 1'b0, 1'b1, 32'h000,      32'h000, 1'b0};
        tbl[13] = '{32'h3FF, 2'd0, 1'b0, 1'b1, 32'h000,      32'h000, 1'b0};
        tbl[14] = '{32'h3FF, 2'd0, 1'b0, 1'b1, 32'h000,      32'h3FF, 1'b1};
        tbl[15] = '{32'h3FF, 2'd3, 1'b0, 1'b1, 32'h000,      32'h3FF, 1'b1};
        tbl[16] = '{32'h3FF, 2'd2, 1'b0, 1'b0, 32'h000,      32'h001, 1'b1};
        tbl[17] = '{32'h3FF, 2'd3, 1'b1, 1'b0, 32'h3FF,      32'h3FF, 1'b0};
        tbl[18] = '{32'h3FF, 2'd3, 1'b0, 1'b1, 32'h000,      32'h000, 1'b0};
        do_reset(32'h0);
        idle(2, 2'd0);
        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].inp, tbl[i].a, tbl[i].cs, tbl[i].wn, tbl[i].wd);
            check($sformatf("tbl%0d_rd", i), s_rd[0], tbl[i].exp_rd);
            check($sformatf("tbl%0d_irq", i), {31'b0, s_irq[0]}, {31'b0, tbl[i].exp_irq});
        end

        // Debounce=4: bounce high 3 / low 1 / high, one capture 4 clocks after last sync2 rise.
        do_reset(32'h0);
        idle(2, 2'd3);
        first = -1;
        for (int c = 0; c < 16; c++) begin
            v = (c == 3) ? 32'h0 : 32'h4;
            cycle(v, 2'd3, 1'b0, 1'b1, 32'h0);
            if (first < 0 && s_rd[1][2]) first = c;
        end
        check("db_latency", first, 11);
        check("db_single", s_rd[1], 32'h004);

        // Debounce=4: a 3-clock pulse never qualifies.
        do_reset(32'h0);
        idle(2, 2'd3);
        for (int c = 0; c < 16; c++) begin
            v = (c < 3) ? 32'h4 : 32'h0;
            cycle(v, 2'd3, 1'b0, 1'b1, 32'h0);
        end
        check("db_glitch", s_rd[1], 32'h000);

        // Clear in the same clock as a new edge on bit 1.
        do_reset(32'h0);
        idle(2, 2'd0);
        cycle(32'h3, 2'd0, 1'b0, 1'b1, 32'h0);
        idle(5, 2'd3);
        in_drv = 32'h0;
        idle(1, 2'd3);
        check("sim_pre_ec", s_rd[0], 32'h003);
        cycle(32'h2, 2'd0, 1'b0, 1'b1, 32'h0);
        cycle(32'h0, 2'd0, 1'b0, 1'b1, 32'h0);
        cycle(32'h0, 2'd0, 1'b0, 1'b1, 32'h0);
        cycle(32'h0, 2'd3, 1'b1, 1'b0, 32'h3);
        cycle(32'h0, 2'd3, 1'b0, 1'b1, 32'h0);
        check("w1c_edge_wins", s_rd[0], 32'h002);
        check("clrall_wins", s_rd[2], 32'h000);

        // Any-edge capture on bit 5, clear between the edges (build 2).
        do_reset(32'h0);
        idle(2, 2'd3);
        for (int c = 0; c < 5; c++) cycle(32'h20, 2'd3, 1'b0, 1'b1, 32'h0);
        check("any_rise", s_rd[2] & 32'h20, 32'h20);
        cycle(32'h20, 2'd3, 1'b1, 1'b0, 32'h0);
        cycle(32'h20, 2'd3, 1'b0, 1'b1, 32'h0);
        check("any_cleared", s_rd[2], 32'h0);
        for (int c = 0; c < 5; c++) cycle(32'h0, 2'd3, 1'b0, 1'b1, 32'h0);
        check("any_fall", s_rd[2] & 32'h20, 32'h20);

        // Full 32-bit build: no truncation of data or mask.
        for (int c = 0; c < 5; c++) cycle(32'hFFFF_FFFF, 2'd0, 1'b0, 1'b1, 32'h0);
        check("w32_data", s_rd[2], 32'hFFFF_FFFF);
        check("w10_data", s_rd[0], 32'h3FF);
        cycle(32'hFFFF_FFFF, 2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF);
        cycle(32'hFFFF_FFFF, 2'd2, 1'b0, 1'b1, 32'h0);
        check("w32_mask", s_rd[2], 32'hFFFF_FFFF);
        check("w10_mask", s_rd[0], 32'h3FF);

        // Asynchronous reset mid-debounce with captures pending.
        cycle(32'h0, 2'd3, 1'b0, 1'b1, 32'h0);
        cycle(32'h0, 2'd3, 1'b0, 1'b1, 32'h0);
        async_reset_check();
        cycle(32'h155, 2'd3, 1'b0, 1'b1, 32'h0);
        reset_n = 1'b1;
        idle(8, 2'd3);

        // Random bus traffic and slowly toggling inputs against the model.
        r = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            r = r ^ ($urandom() & $urandom() & $urandom() & $urandom());
            cycle(r, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
